// File: rtl/watch_time_setter_pkg.sv
// Shared types and calendar helpers for the watch time editor.
// Field codes, reset time, days-in-month and single-field step arithmetic.
package watch_time_setter_pkg;

    typedef enum logic [2:0] {
        FieldYr   = 3'd0,
        FieldMo   = 3'd1,
        FieldDay  = 3'd2,
        FieldHr   = 3'd3,
        FieldMin  = 3'd4,
        FieldSec  = 3'd5,
        FieldNone = 3'd7
    } field_e;

    typedef struct packed {
        logic [11:0] year;
        logic [7:0]  month;
        logic [7:0]  day;
        logic [7:0]  hour;
        logic [7:0]  minute;
        logic [7:0]  second;
    } time_t;

    localparam time_t ResetTime = '{
        year:   12'd2021,
        month:  8'd5,
        day:    8'd30,
        hour:   8'd18,
        minute: 8'd32,
        second: 8'd0
    };

    function automatic logic is_leap(input logic [11:0] year);
        return ((year[1:0] == 2'b00) && ((year % 12'd100) != 12'd0)) ||
               ((year % 12'd400) == 12'd0);
    endfunction

    function automatic logic [7:0] days_in_month(input logic [11:0] year,
                                                 input logic [7:0]  month);
        case (month)
            8'd2:                     return is_leap(year) ? 8'd29 : 8'd28;
            8'd4, 8'd6, 8'd9, 8'd11:  return 8'd30;
            default:                  return 8'd31;
        endcase
    endfunction

    // One up/down step of the selected field with wrap; a year or month change
    // pulls the day back into the new month's range in the same update.
    function automatic time_t step_field(input time_t  t,
                                         input field_e f,
                                         input logic   up);
        time_t      r;
        logic [7:0] md;
        r  = t;
        md = days_in_month(t.year, t.month);
        case (f)
            FieldYr: begin
                if (up) r.year = (t.year == 12'd4095) ? 12'd1 : t.year + 12'd1;
                else    r.year = (t.year <= 12'd1) ? 12'd4095 : t.year - 12'd1;
            end
            FieldMo: begin
                if (up) r.month = (t.month >= 8'd12) ? 8'd1 : t.month + 8'd1;
                else    r.month = (t.month <= 8'd1) ? 8'd12 : t.month - 8'd1;
            end
            FieldDay: begin
                if (up) r.day = (t.day >= md) ? 8'd1 : t.day + 8'd1;
                else    r.day = (t.day <= 8'd1) ? md : t.day - 8'd1;
            end
            FieldHr: begin
                if (up) r.hour = (t.hour >= 8'd23) ? 8'd0 : t.hour + 8'd1;
                else    r.hour = (t.hour == 8'd0) ? 8'd23 : t.hour - 8'd1;
            end
            FieldMin: begin
                if (up) r.minute = (t.minute >= 8'd59) ? 8'd0 : t.minute + 8'd1;
                else    r.minute = (t.minute == 8'd0) ? 8'd59 : t.minute - 8'd1;
            end
            FieldSec: begin
                if (up) r.second = (t.second >= 8'd59) ? 8'd0 : t.second + 8'd1;
                else    r.second = (t.second == 8'd0) ? 8'd59 : t.second - 8'd1;
            end
            default: r = t;
        endcase
        if (f == FieldYr || f == FieldMo) begin
            md = days_in_month(r.year, r.month);
            if (r.day > md) r.day = md;
        end
        return r;
    endfunction

endpackage

// File: rtl/watch_time_setter_debounce.sv
// Push-button front end: 2-FF sync, level debounce, registered press pulse
// and optional hold-to-repeat.
module watch_time_setter_debounce #(
    parameter int unsigned DEB_CYCLES   = 500_000,
    parameter int unsigned REPEAT_DELAY = 25_000_000,
    parameter int unsigned REPEAT_RATE  = 5_000_000,
    parameter bit          REPEAT_EN    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic restart,
    output logic press
);

    localparam int unsigned DW     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW     = (RepMax > 1) ? $clog2(RepMax) : 1;

    logic [1:0]    sync_q;
    logic          deb_q;
    logic [DW-1:0] deb_cnt_q;
    logic [RW-1:0] rep_cnt_q;
    logic          rep_phase_q;
    logic          press_q;

    logic sync_lvl;
    logic accept;
    logic rise;
    logic rep_fire;

    always_comb begin
        sync_lvl = sync_q[1];
        accept   = (sync_lvl != deb_q) && (deb_cnt_q == DW'(DEB_CYCLES - 1));
        rise     = accept && sync_lvl;
        // Initial delay first, then the shorter period until release or restart.
        rep_fire = REPEAT_EN && deb_q && !accept && !restart &&
                   (rep_phase_q ? (rep_cnt_q == RW'(REPEAT_RATE - 1))
                                : (rep_cnt_q == RW'(REPEAT_DELAY - 1)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= '0;
            deb_q       <= 1'b0;
            deb_cnt_q   <= '0;
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};

            if (sync_lvl == deb_q) begin
                deb_cnt_q <= '0;
            end else if (accept) begin
                deb_q     <= sync_lvl;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + DW'(1);
            end

            if (!REPEAT_EN || !deb_q || accept || restart) begin
                rep_cnt_q   <= '0;
                rep_phase_q <= 1'b0;
            end else if (rep_fire) begin
                rep_cnt_q   <= '0;
                rep_phase_q <= 1'b1;
            end else begin
                rep_cnt_q <= rep_cnt_q + RW'(1);
            end

            press_q <= rise || rep_fire;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/watch_time_setter.sv
// Button-driven time editor: snapshots the running time, steps through fields,
// and emits the edited time with a one-cycle set_time strobe on commit.
module watch_time_setter
    import watch_time_setter_pkg::*;
#(
    parameter int unsigned DEB_CYCLES     = 500_000,
    parameter int unsigned REPEAT_DELAY   = 25_000_000,
    parameter int unsigned REPEAT_RATE    = 5_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    parameter int unsigned BLINK_HALF     = 12_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [11:0] cur_year,
    input  logic [7:0]  cur_month,
    input  logic [7:0]  cur_day,
    input  logic [7:0]  cur_hour,
    input  logic [7:0]  cur_minute,
    input  logic [7:0]  cur_second,
    output logic [51:0] bin_time,
    output logic        set_time,
    output logic        edit_active,
    output logic [2:0]  edit_field,
    output logic        blink
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    typedef enum logic [2:0] {
        StIdle, StEditYr, StEditMo, StEditDay, StEditHr, StEditMin, StEditSec, StCommit
    } state_e;

    logic mode_press;
    logic up_press;
    logic down_press;

    watch_time_setter_debounce #(
        .DEB_CYCLES  (DEB_CYCLES),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE),
        .REPEAT_EN   (1'b0)
    ) u_btn_mode (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn_mode),
        .restart(1'b0),
        .press  (mode_press)
    );

    // A field change restarts any hold-repeat in progress on up/down.
    watch_time_setter_debounce #(
        .DEB_CYCLES  (DEB_CYCLES),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE),
        .REPEAT_EN   (1'b1)
    ) u_btn_up (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn_up),
        .restart(mode_press),
        .press  (up_press)
    );

    watch_time_setter_debounce #(
        .DEB_CYCLES  (DEB_CYCLES),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE),
        .REPEAT_EN   (1'b1)
    ) u_btn_down (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn_down),
        .restart(mode_press),
        .press  (down_press)
    );

    state_e        state_q;
    time_t         shadow_q;
    logic          set_time_q;
    logic          edit_active_q;
    field_e        field_q;
    logic          blink_q;
    logic [TW-1:0] tout_q;
    logic [BW-1:0] blink_cnt_q;

    time_t cur_time;
    time_t adj_time;

    always_comb begin
        cur_time = '{year:   cur_year,
                     month:  cur_month,
                     day:    cur_day,
                     hour:   cur_hour,
                     minute: cur_minute,
                     second: cur_second};
        adj_time = step_field(shadow_q, field_q, up_press);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            shadow_q      <= ResetTime;
            set_time_q    <= 1'b0;
            edit_active_q <= 1'b0;
            field_q       <= FieldNone;
            blink_q       <= 1'b0;
            tout_q        <= '0;
            blink_cnt_q   <= '0;
        end else begin
            set_time_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    tout_q      <= '0;
                    blink_cnt_q <= '0;
                    blink_q     <= 1'b0;
                    if (mode_press) begin
                        shadow_q      <= cur_time;
                        state_q       <= StEditYr;
                        edit_active_q <= 1'b1;
                        field_q       <= FieldYr;
                    end
                end
                StCommit: begin
                    state_q <= StIdle;
                end
                default: begin
                    if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
                        blink_cnt_q <= '0;
                        blink_q     <= ~blink_q;
                    end else begin
                        blink_cnt_q <= blink_cnt_q + BW'(1);
                    end

                    // Mode has priority; a coincident up/down is dropped.
                    if (mode_press) begin
                        tout_q <= '0;
                        if (state_q == StEditSec) begin
                            state_q       <= StCommit;
                            set_time_q    <= 1'b1;
                            edit_active_q <= 1'b0;
                            field_q       <= FieldNone;
                            blink_q       <= 1'b0;
                            blink_cnt_q   <= '0;
                        end else begin
                            state_q <= state_e'(state_q + 3'd1);
                            field_q <= field_e'(field_q + 3'd1);
                        end
                    end else if (up_press || down_press) begin
                        tout_q <= '0;
                        if (up_press ^ down_press) shadow_q <= adj_time;
                    end else if (tout_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_q       <= StIdle;
                        edit_active_q <= 1'b0;
                        field_q       <= FieldNone;
                        blink_q       <= 1'b0;
                        blink_cnt_q   <= '0;
                        tout_q        <= '0;
                    end else begin
                        tout_q <= tout_q + TW'(1);
                    end
                end
            endcase
        end
    end

    assign bin_time    = shadow_q;
    assign set_time    = set_time_q;
    assign edit_active = edit_active_q;
    assign edit_field  = field_q;
    assign blink       = blink_q;

endmodule

// File: tb/tb_watch_time_setter.sv
// Directed self-checking bench for watch_time_setter with shortened timing parameters.
module tb_watch_time_setter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic [11:0] cur_year = '0;
    logic [7:0]  cur_month = '0;
    logic [7:0]  cur_day = '0;
    logic [7:0]  cur_hour = '0;
    logic [7:0]  cur_minute = '0;
    logic [7:0]  cur_second = '0;
    logic [51:0] bin_time;
    logic        set_time;
    logic        edit_active;
    logic [2:0]  edit_field;
    logic        blink;

    int n_cmp = 0;
    int n_fail = 0;
    int set_count = 0;

    watch_time_setter #(
        .DEB_CYCLES    (4),
        .REPEAT_DELAY  (20),
        .REPEAT_RATE   (5),
        .TIMEOUT_CYCLES(200),
        .BLINK_HALF    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .cur_year   (cur_year),
        .cur_month  (cur_month),
        .cur_day    (cur_day),
        .cur_hour   (cur_hour),
        .cur_minute (cur_minute),
        .cur_second (cur_second),
        .bin_time   (bin_time),
        .set_time   (set_time),
        .edit_active(edit_active),
        .edit_field (edit_field),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (set_time === 1'b1) set_count++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [51:0] tm(input int y, input int mo, input int d,
                                       input int h, input int mi, input int s);
        return {y[11:0], mo[7:0], d[7:0], h[7:0], mi[7:0], s[7:0]};
    endfunction

    task automatic set_cur(input logic [51:0] t);
        {cur_year, cur_month, cur_day, cur_hour, cur_minute, cur_second} = t;
    endtask

    task automatic do_reset();
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic press(input logic m, input logic u, input logic d);
        btn_mode = m;
        btn_up   = u;
        btn_down = d;
        repeat (10) @(negedge clk);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [51:0] exp_t;
        exp_t = tm(2021, 5, 30, 18, 32, 0);
        do_reset();
        n_cmp++;
        if (bin_time !== exp_t) begin
            $display("FAIL reset_bin_time: got %h required %h", bin_time, exp_t); n_fail++;
        end
        n_cmp++;
        if (set_time !== 1'b0) begin
            $display("FAIL reset_set_time: got %b required 0", set_time); n_fail++;
        end
        n_cmp++;
        if (edit_active !== 1'b0) begin
            $display("FAIL reset_edit_active: got %b required 0", edit_active); n_fail++;
        end
        n_cmp++;
        if (edit_field !== 3'd7) begin
            $display("FAIL reset_edit_field: got %0d required 7", edit_field); n_fail++;
        end
        n_cmp++;
        if (blink !== 1'b0) begin
            $display("FAIL reset_blink: got %b required 0", blink); n_fail++;
        end
    endtask

    task automatic test_full_commit();
        logic [51:0] exp_t;
        int start;
        exp_t = tm(2024, 2, 29, 10, 0, 0);
        do_reset();
        set_cur(exp_t);
        start = set_count;
        for (int i = 0; i < 6; i++) begin
            press(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (edit_field !== 3'(i) || edit_active !== 1'b1) begin
                $display("FAIL commit_field_step%0d: got field %0d active %b required field %0d active 1",
                         i, edit_field, edit_active, i);
                n_fail++;
            end
        end
        press(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (set_count - start !== 1) begin
            $display("FAIL commit_pulse_count: got %0d required 1", set_count - start); n_fail++;
        end
        n_cmp++;
        if (bin_time !== exp_t) begin
            $display("FAIL commit_bin_time: got %h required %h", bin_time, exp_t); n_fail++;
        end
        n_cmp++;
        if (edit_active !== 1'b0 || edit_field !== 3'd7) begin
            $display("FAIL commit_idle: got active %b field %0d required active 0 field 7",
                     edit_active, edit_field);
            n_fail++;
        end
    endtask

    task automatic test_leap_clamp();
        logic [51:0] exp_t;
        do_reset();
        set_cur(tm(2024, 2, 29, 10, 0, 0));
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        exp_t = tm(2025, 2, 28, 10, 0, 0);
        n_cmp++;
        if (bin_time !== exp_t) begin
            $display("FAIL leap_up_clamp: got %h required %h", bin_time, exp_t); n_fail++;
        end
        press(1'b0, 1'b0, 1'b1);
        exp_t = tm(2024, 2, 28, 10, 0, 0);
        n_cmp++;
        if (bin_time !== exp_t) begin
            $display("FAIL leap_down_keep28: got %h required %h", bin_time, exp_t); n_fail++;
        end
    endtask

    task automatic test_wraps();
        logic [51:0] exp_t;
        do_reset();
        set_cur(tm(4095, 1, 15, 23, 0, 0));
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (bin_time[51:40] !== 12'd1) begin
            $display("FAIL wrap_year: got %0d required 1", bin_time[51:40]); n_fail++;
        end
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bin_time[39:32] !== 8'd12) begin
            $display("FAIL wrap_month: got %0d required 12", bin_time[39:32]); n_fail++;
        end
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        exp_t = tm(1, 12, 15, 0, 0, 0);
        n_cmp++;
        if (bin_time !== exp_t) begin
            $display("FAIL wrap_hour_full: got %h required %h", bin_time, exp_t); n_fail++;
        end
    endtask

    task automatic test_repeat();
        int offs[6] = '{19, 20, 24, 25, 30, 35};
        int vals[6] = '{59, 0, 0, 1, 2, 3};
        int w;
        do_reset();
        set_cur(tm(2000, 1, 1, 0, 58, 0));
        for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (edit_field !== 3'd4) begin
            $display("FAIL repeat_in_min: got field %0d required 4", edit_field); n_fail++;
        end
        btn_up = 1'b1;
        w = 0;
        while (bin_time[15:8] !== 8'd59 && w < 30) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (w >= 30) begin
            $display("FAIL repeat_first_step: got minute %0d required 59", bin_time[15:8]);
            n_fail++;
        end
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            for (int j = 0; j < 6; j++) begin
                if (offs[j] == k) begin
                    n_cmp++;
                    if (bin_time[15:8] !== 8'(vals[j])) begin
                        $display("FAIL repeat_at_%0d: got minute %0d required %0d",
                                 k, bin_time[15:8], vals[j]);
                        n_fail++;
                    end
                end
            end
        end
        btn_up = 1'b0;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (bin_time[15:8] !== 8'd4) begin
            $display("FAIL repeat_after_release: got minute %0d required 4", bin_time[15:8]);
            n_fail++;
        end
        repeat (30) @(negedge clk);
        n_cmp++;
        if (bin_time[15:8] !== 8'd4) begin
            $display("FAIL repeat_stopped: got minute %0d required 4", bin_time[15:8]);
            n_fail++;
        end
    endtask

    task automatic test_timeout();
        logic [51:0] exp_t;
        int start;
        int toggles;
        int w;
        logic prev;
        exp_t = tm(1999, 12, 31, 23, 59, 59);
        do_reset();
        set_cur(exp_t);
        start = set_count;
        press(1'b1, 1'b0, 1'b0);
        toggles = 0;
        prev = blink;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (blink !== prev) toggles++;
            prev = blink;
        end
        n_cmp++;
        if (toggles !== 4) begin
            $display("FAIL blink_toggles: got %0d required 4", toggles); n_fail++;
        end
        repeat (100) @(negedge clk);
        n_cmp++;
        if (edit_active !== 1'b1) begin
            $display("FAIL timeout_early: got active %b required 1", edit_active); n_fail++;
        end
        set_cur(tm(1, 1, 1, 1, 1, 1));
        w = 0;
        while (edit_active !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (w >= 100) begin
            $display("FAIL timeout_exit: got active %b required 0", edit_active); n_fail++;
        end
        n_cmp++;
        if (edit_field !== 3'd7 || blink !== 1'b0) begin
            $display("FAIL timeout_idle_outputs: got field %0d blink %b required field 7 blink 0",
                     edit_field, blink);
            n_fail++;
        end
        n_cmp++;
        if (set_count !== start) begin
            $display("FAIL timeout_no_set: got %0d pulses required 0", set_count - start);
            n_fail++;
        end
        n_cmp++;
        if (bin_time !== exp_t) begin
            $display("FAIL timeout_shadow_kept: got %h required %h", bin_time, exp_t); n_fail++;
        end
    endtask

    task automatic test_reset_mid_edit();
        logic [51:0] exp_t;
        int start;
        exp_t = tm(2021, 5, 30, 18, 32, 0);
        do_reset();
        set_cur(tm(2030, 6, 15, 12, 30, 45));
        start = set_count;
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (edit_field !== 3'd2) begin
            $display("FAIL midreset_in_day: got field %0d required 2", edit_field); n_fail++;
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (edit_active !== 1'b0 || edit_field !== 3'd7 || blink !== 1'b0 || set_time !== 1'b0) begin
            $display("FAIL midreset_async: got active %b field %0d blink %b set %b required 0 7 0 0",
                     edit_active, edit_field, blink, set_time);
            n_fail++;
        end
        n_cmp++;
        if (bin_time !== exp_t) begin
            $display("FAIL midreset_bin_time: got %h required %h", bin_time, exp_t); n_fail++;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (set_count !== start || edit_active !== 1'b0) begin
            $display("FAIL midreset_after: got pulses %0d active %b required 0 0",
                     set_count - start, edit_active);
            n_fail++;
        end
    endtask

    task automatic test_simultaneous();
        logic [51:0] exp_t;
        do_reset();
        press(1'b0, 1'b1, 1'b0);
        exp_t = tm(2021, 5, 30, 18, 32, 0);
        n_cmp++;
        if (bin_time !== exp_t || edit_active !== 1'b0) begin
            $display("FAIL idle_up_ignored: got %h active %b required %h active 0",
                     bin_time, edit_active, exp_t);
            n_fail++;
        end
        exp_t = tm(2023, 3, 31, 8, 0, 0);
        set_cur(exp_t);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (bin_time !== exp_t) begin
            $display("FAIL up_down_ignored: got %h required %h", bin_time, exp_t); n_fail++;
        end
        press(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (edit_field !== 3'd1 || bin_time !== exp_t) begin
            $display("FAIL mode_wins: got field %0d time %h required field 1 time %h",
                     edit_field, bin_time, exp_t);
            n_fail++;
        end
        btn_mode = 1'b1;
        repeat (3) @(negedge clk);
        btn_mode = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (edit_field !== 3'd1 || edit_active !== 1'b1) begin
            $display("FAIL glitch_ignored: got field %0d active %b required field 1 active 1",
                     edit_field, edit_active);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_full_commit();
        test_leap_clamp();
        test_wraps();
        test_repeat();
        test_timeout();
        test_reset_mid_edit();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
